// File: rtl/base_aquiesce_if.sv
// base_aquiesce_if: request/response handshake bundle for base_aquiesce.
//   i_v/i_r  : upstream request valid / ready
//   o_v/o_r  : downstream request valid / ready
//   cmpl_v   : completion strobe from the downstream engine
// master: the environment (drives i_v, o_r, cmpl_v).
// slave : the gate itself (drives i_r, o_v).
interface base_aquiesce_if;
  logic i_v;
  logic i_r;
  logic o_v;
  logic o_r;
  logic cmpl_v;

  modport master (
    output i_v,
    output o_r,
    output cmpl_v,
    input  i_r,
    input  o_v
  );

  modport slave (
    input  i_v,
    input  o_r,
    input  cmpl_v,
    output i_r,
    output o_v
  );
endinterface

// File: rtl/base_aquiesce.sv
// base_aquiesce: valid/ready flow gate with outstanding-transaction tracking
// and a quiesce handshake. Caps requests in flight at max_outst; on
// quiesce_req it closes the gate, waits for outstanding work to complete,
// then holds quiesce_ack while idle and closed.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   bus (slave)  : i_v/i_r upstream, o_v/o_r downstream, cmpl_v completions
//   quiesce_req  : level request to stop and drain
//   quiesce_ack  : registered, high while idle and closed
//   outst        : registered count of requests in flight
//   err          : registered, sticky completion-underflow flag
module base_aquiesce #(
  parameter int unsigned cnt_width = 8,
  parameter int unsigned max_outst = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  base_aquiesce_if.slave       bus,
  input  logic                 quiesce_req,
  output logic                 quiesce_ack,
  output logic [cnt_width-1:0] outst,
  output logic                 err
);

  localparam logic [cnt_width-1:0] MAX_C = cnt_width'(max_outst);

  typedef enum logic [1:0] {
    CLOSED   = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2,
    QUIESCED = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [cnt_width-1:0] outst_q, outst_d;
  logic                 err_q, err_d;
  logic                 ack_q, ack_d;
  logic                 en;
  logic                 issue;

  always_comb begin
    // Gate is a pure function of registered state plus the live request,
    // so quiesce_req closes it within the same cycle.
    en       = (state_q == RUN) & ~quiesce_req & (outst_q < MAX_C);
    bus.i_r  = en & bus.o_r;
    bus.o_v  = en & bus.i_v;
    issue    = en & bus.i_v & bus.o_r;

    outst_d  = outst_q;
    err_d    = err_q;
    if (issue && !bus.cmpl_v) begin
      outst_d = outst_q + 1'b1;
    end else if (!issue && bus.cmpl_v) begin
      if (outst_q == '0) begin
        err_d = 1'b1;
      end else begin
        outst_d = outst_q - 1'b1;
      end
    end

    state_d = state_q;
    unique case (state_q)
      CLOSED:   state_d = quiesce_req ? DRAIN : RUN;
      RUN:      if (quiesce_req) state_d = (outst_d == '0) ? QUIESCED : DRAIN;
      DRAIN: begin
        if (!quiesce_req)          state_d = RUN;
        else if (outst_d == '0)    state_d = QUIESCED;
      end
      QUIESCED: if (!quiesce_req) state_d = RUN;
      default:  state_d = CLOSED;
    endcase

    ack_d = (state_d == QUIESCED);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CLOSED;
      outst_q <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
    end
  end

  assign quiesce_ack = ack_q;
  assign outst       = outst_q;
  assign err         = err_q;

endmodule

// File: tb/tb_base_aquiesce.sv
module tb_base_aquiesce;
  logic       clk;
  logic       rstn;
  logic       quiesce_req;
  logic       quiesce_ack;
  logic [7:0] outst;
  logic       err;
  int         tests;
  int         fails;

  base_aquiesce_if bus ();

  base_aquiesce #(
    .cnt_width (8),
    .max_outst (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus.slave),
    .quiesce_req (quiesce_req),
    .quiesce_ack (quiesce_ack),
    .outst       (outst),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstn = 1'b0;
    bus.i_v = 1'b1;
    bus.o_r = 1'b1;
    bus.cmpl_v = 1'b0;
    quiesce_req = 1'b0;

    // Reset: gate closed regardless of i_v/o_r
    @(negedge clk); @(negedge clk);
    chk("rst_o_v", 32'(bus.o_v), 0);
    chk("rst_i_r", 32'(bus.i_r), 0);
    chk("rst_outst", 32'(outst), 0);
    chk("rst_ack", 32'(quiesce_ack), 0);
    chk("rst_err", 32'(err), 0);

    rstn = 1'b1;
    #1 chk("closed_o_v", 32'(bus.o_v), 0);

    // First edge after release: CLOSED -> RUN; gate open from here
    @(negedge clk);
    chk("open_o_v", 32'(bus.o_v), 1);
    chk("open_outst", 32'(outst), 0);
    @(negedge clk); chk("inc1", 32'(outst), 1);
    @(negedge clk); chk("inc2", 32'(outst), 2);
    @(negedge clk); chk("inc3", 32'(outst), 3);
    chk("inc3_o_v", 32'(bus.o_v), 1);
    @(negedge clk);
    chk("cap_outst", 32'(outst), 4);
    chk("cap_o_v", 32'(bus.o_v), 0);
    chk("cap_i_r", 32'(bus.i_r), 0);
    @(negedge clk);
    chk("cap_hold", 32'(outst), 4);

    // Completion at full: gate stays closed this cycle, reopens next
    bus.cmpl_v = 1'b1;
    #1 chk("full_cmpl_o_v", 32'(bus.o_v), 0);
    @(negedge clk);
    bus.cmpl_v = 1'b0;
    chk("reopen_outst", 32'(outst), 3);
    #1 chk("reopen_o_v", 32'(bus.o_v), 1);
    @(negedge clk);
    chk("one_more_outst", 32'(outst), 4);
    chk("one_more_o_v", 32'(bus.o_v), 0);

    // Drain down to 2 then issue+completion together
    bus.i_v = 1'b0;
    bus.cmpl_v = 1'b1;
    @(negedge clk); chk("dec3", 32'(outst), 3);
    @(negedge clk); chk("dec2", 32'(outst), 2);
    bus.i_v = 1'b1;
    #1 chk("simul_o_v", 32'(bus.o_v), 1);
    @(negedge clk);
    chk("simul_outst", 32'(outst), 2);
    chk("simul_err", 32'(err), 0);

    // Drain: grow to 3, raise quiesce_req, gate drops immediately
    bus.cmpl_v = 1'b0;
    @(negedge clk); chk("pre_drain", 32'(outst), 3);
    quiesce_req = 1'b1;
    #1 chk("drain_o_v", 32'(bus.o_v), 0);
    @(negedge clk);
    bus.cmpl_v = 1'b1;                      // counted at edge k
    @(negedge clk);
    bus.cmpl_v = 1'b0;
    chk("drain_c1", 32'(outst), 2);
    chk("drain_ack0", 32'(quiesce_ack), 0);
    @(negedge clk);
    bus.cmpl_v = 1'b1;                      // edge k+2
    @(negedge clk);
    bus.cmpl_v = 1'b0;
    chk("drain_c2", 32'(outst), 1);
    @(negedge clk);
    chk("drain_gap_o_v", 32'(bus.o_v), 0);
    @(negedge clk);
    bus.cmpl_v = 1'b1;                      // edge k+5
    chk("drain_ack_pre", 32'(quiesce_ack), 0);
    @(negedge clk);
    bus.cmpl_v = 1'b0;
    chk("drain_ack1", 32'(quiesce_ack), 1);
    chk("drain_outst0", 32'(outst), 0);
    quiesce_req = 1'b0;
    #1 chk("q_drop_o_v", 32'(bus.o_v), 0);
    @(negedge clk);
    chk("q_drop_ack", 32'(quiesce_ack), 0);
    chk("q_drop_open", 32'(bus.o_v), 1);

    // Abort: DRAIN with outst=2, drop request -> RUN, no ack
    @(negedge clk); chk("ab_inc1", 32'(outst), 1);
    @(negedge clk); chk("ab_inc2", 32'(outst), 2);
    quiesce_req = 1'b1;
    @(negedge clk);
    chk("ab_drain_ack", 32'(quiesce_ack), 0);
    chk("ab_drain_o_v", 32'(bus.o_v), 0);
    quiesce_req = 1'b0;
    bus.i_v = 1'b0;
    @(negedge clk);
    chk("ab_ack", 32'(quiesce_ack), 0);
    chk("ab_outst", 32'(outst), 2);
    chk("ab_i_r", 32'(bus.i_r), 1);
    bus.cmpl_v = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.cmpl_v = 1'b0;
    chk("ab_cnt0", 32'(outst), 0);
    chk("ab_ack_never", 32'(quiesce_ack), 0);

    // Idle quiesce: ack one cycle after request
    quiesce_req = 1'b1;
    @(negedge clk);
    chk("idle_ack", 32'(quiesce_ack), 1);

    // Underflow while quiesced
    bus.cmpl_v = 1'b1;
    @(negedge clk);
    bus.cmpl_v = 1'b0;
    chk("uf_err", 32'(err), 1);
    chk("uf_outst", 32'(outst), 0);
    chk("uf_ack", 32'(quiesce_ack), 1);
    quiesce_req = 1'b0;
    @(negedge clk);
    chk("uf_ack_fall", 32'(quiesce_ack), 0);
    bus.i_v = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("uf_traffic_outst", 32'(outst), 2);
    chk("uf_sticky", 32'(err), 1);

    // Async reset clears everything immediately
    rstn = 1'b0;
    #1;
    chk("rst2_err", 32'(err), 0);
    chk("rst2_outst", 32'(outst), 0);
    chk("rst2_o_v", 32'(bus.o_v), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
